// File: rtl/result_unloader_pkg.sv
// result_unloader_pkg: FSM encoding, element geometry, host mode/address codes and Fp24 word order for the unloader.
package result_unloader_pkg;
  localparam int NUM_WORDS = 24;
  localparam logic [3:0] REF_RESULT = 4'd9;
  localparam logic [7:0] RAM_P_B2_0 = 8'h30;
  typedef logic [4:0] idx_t;
  localparam logic [2:0] IDLE = 3'd0, WAIT_IDLE = 3'd1, ISSUE = 3'd2, WAIT_LAT = 3'd3, CAPTURE = 3'd4, STREAM = 3'd5;
  // word k -> result name digits {i,j,b,c}, e.g. k=12 -> 1000, k=23 -> 1211
  function automatic logic [15:0] result_name(input int k);
    return {4'(k / 12), 4'((k % 12) / 4), 4'((k % 4) / 2), 4'(k % 2)};
  endfunction
endpackage

// File: rtl/result_unloader_if.sv
// result_unloader_if: request, core-bus and result-stream signals of the unloader (master = unloader side).
interface result_unloader_if import result_unloader_pkg::*; #(
  parameter int WORD_SIZE = 64,
  parameter int RAM_ADDR_SIZE = 8,
  parameter int MODE_SIZE = 4
);
  logic req_valid, req_ready;
  logic [RAM_ADDR_SIZE-1:0] req_addr;
  logic core_busy, bus_own;
  logic [MODE_SIZE-1:0] o_inputmode;
  logic [RAM_ADDR_SIZE-1:0] o_raddr;
  logic [NUM_WORDS*WORD_SIZE-1:0] result_bus;
  logic out_valid, out_ready, out_last;
  logic [WORD_SIZE-1:0] out_data;
  idx_t out_idx;
  modport master(
    input req_valid, req_addr, core_busy, result_bus, out_ready,
    output req_ready, bus_own, o_inputmode, o_raddr, out_valid, out_data, out_idx, out_last
  );
  modport slave(
    output req_valid, req_addr, core_busy, result_bus, out_ready,
    input req_ready, bus_own, o_inputmode, o_raddr, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/result_unloader_shift_buf.sv
// unload_shift_buf: shadow copy of the result bus with indexed read; UNLOAD_CHECKSUM_EN adds an XOR word at index NUM_WORDS.
module unload_shift_buf import result_unloader_pkg::*; #(
  parameter int WORD_SIZE = 64
) (
  input  logic clk,
  input  logic load,
  input  logic [NUM_WORDS*WORD_SIZE-1:0] din,
  input  idx_t rd_idx,
  output logic [WORD_SIZE-1:0] rd_data
);
  logic [WORD_SIZE-1:0] shadow [NUM_WORDS];
  always_ff @(posedge clk)
    if (load) for (int i = 0; i < NUM_WORDS; i++) shadow[i] <= din[i*WORD_SIZE +: WORD_SIZE];
`ifdef UNLOAD_CHECKSUM_EN
  logic [WORD_SIZE-1:0] sum, sum_d;
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NUM_WORDS; i++) sum_d = sum_d ^ din[i*WORD_SIZE +: WORD_SIZE];
  end
  always_ff @(posedge clk)
    if (load) sum <= sum_d;
  assign rd_data = rd_idx == idx_t'(NUM_WORDS) ? sum : shadow[rd_idx];
`else
  assign rd_data = shadow[rd_idx];
`endif
endmodule

// File: rtl/result_unloader.sv
// result_unloader: reads one Fp24 result from the core in result-reference mode and streams its words; UNLOAD_CHECKSUM_EN appends an XOR beat.
module result_unloader import result_unloader_pkg::*; #(
  parameter int WORD_SIZE = 64,
  parameter int RAM_ADDR_SIZE = 8,
  parameter int MODE_SIZE = 4,
  parameter logic [MODE_SIZE-1:0] REF_MODE = MODE_SIZE'(REF_RESULT),
  parameter int RD_LATENCY = 3
) (
  input logic clk,
  input logic rst,
  result_unloader_if.master bus
);
`ifdef UNLOAD_CHECKSUM_EN
  localparam idx_t LAST_IDX = idx_t'(NUM_WORDS);
`else
  localparam idx_t LAST_IDX = idx_t'(NUM_WORDS - 1);
`endif
  logic [2:0] state;
  logic [RAM_ADDR_SIZE-1:0] addr;
  logic [3:0] cnt;
  logic [WORD_SIZE-1:0] rd_data;
  logic load;
  idx_t rd_idx;
  // snapshot on the edge that ends the last latency cycle, so the CAPTURE cycle already sees word 0
  assign load = state == WAIT_LAT && cnt == 4'd0;
  assign rd_idx = state == STREAM ? bus.out_idx + 5'd1 : 5'd0;
  unload_shift_buf #(.WORD_SIZE(WORD_SIZE)) u_buf (
    .clk(clk), .load(load), .din(bus.result_bus), .rd_idx(rd_idx), .rd_data(rd_data)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      cnt <= '0;
      bus.req_ready <= 1'b0;
      bus.bus_own <= 1'b0;
      bus.o_inputmode <= '0;
      bus.o_raddr <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_idx <= '0;
      bus.out_last <= 1'b0;
    end else
      case (state)
        IDLE:
          if (bus.req_valid && bus.req_ready) begin
            addr <= bus.req_addr;
            bus.req_ready <= 1'b0;
            state <= WAIT_IDLE;
          end else bus.req_ready <= 1'b1;
        WAIT_IDLE:
          if (!bus.core_busy) begin
            bus.bus_own <= 1'b1;
            bus.o_inputmode <= REF_MODE;
            bus.o_raddr <= addr;
            state <= ISSUE;
          end
        ISSUE: begin
          cnt <= 4'(RD_LATENCY - 1);
          state <= WAIT_LAT;
        end
        WAIT_LAT:
          if (cnt == 4'd0) state <= CAPTURE;
          else cnt <= cnt - 4'd1;
        CAPTURE: begin
          bus.bus_own <= 1'b0;
          bus.out_valid <= 1'b1;
          bus.out_idx <= '0;
          bus.out_data <= rd_data;
          bus.out_last <= LAST_IDX == 5'd0;
          state <= STREAM;
        end
        STREAM:
          if (bus.out_ready && bus.out_last) begin
            bus.out_valid <= 1'b0;
            bus.out_last <= 1'b0;
            bus.req_ready <= 1'b1;
            state <= IDLE;
          end else if (bus.out_ready) begin
            bus.out_idx <= rd_idx;
            bus.out_data <= rd_data;
            bus.out_last <= rd_idx == LAST_IDX;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_result_unloader.sv
// tb_result_unloader: transaction-level model of the unloader plus directed scenarios with literal expectations.
module tb_result_unloader;
  import result_unloader_pkg::*;
  localparam int RD_LATENCY = 3;
`ifdef UNLOAD_CHECKSUM_EN
  localparam int NB = 25;
`else
  localparam int NB = 24;
`endif
  typedef struct packed {logic [63:0] data; logic [4:0] idx; logic last;} beat_t;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  result_unloader_if ifc ();
  result_unloader #(.RD_LATENCY(RD_LATENCY)) dut (.clk(clk), .rst(rst), .bus(ifc));
  int total = 0, bad = 0;
  bit armed = 0, rdy_exp = 0, active = 0, waiting = 0, streaming = 0, bp = 0;
  int own_left = 0, own_run = 0, last_own_len = 0;
  logic [7:0] cur_addr = 0;
  logic [63:0] cur_base = 0, mem_base = 0;
  beat_t q[$], log[$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  // element model: request -> wait for idle core -> own bus RD_LATENCY+2 cycles -> stream queued beats
  always @(posedge clk) begin
    if (rst) begin
      armed = 1; rdy_exp = 0; active = 0; waiting = 0; streaming = 0; own_left = 0;
      q.delete();
    end else if (armed) begin
      if (ifc.out_valid && ifc.out_ready) log.push_back('{ifc.out_data, ifc.out_idx, ifc.out_last});
      if (streaming && ifc.out_ready) begin
        q.delete(0);
        if (q.size() == 0) begin streaming = 0; active = 0; end
      end
      if (own_left > 0) begin
        own_left--;
        if (own_left == 0) streaming = 1;
      end
      if (waiting && !ifc.core_busy) begin waiting = 0; own_left = RD_LATENCY + 2; end
      if (rdy_exp && ifc.req_valid) begin
        logic [63:0] x;
        x = 0;
        active = 1; waiting = 1; cur_addr = ifc.req_addr; cur_base = mem_base;
        for (int k = 0; k < 24; k++) begin
          q.push_back('{cur_base + 64'(k), 5'(k), NB == 24 && k == 23});
          x = x ^ (cur_base + 64'(k));
        end
`ifdef UNLOAD_CHECKSUM_EN
        q.push_back('{x, 5'd24, 1'b1});
`endif
      end
      rdy_exp = !active;
    end
  end
  always @(negedge clk)
    if (armed) begin
      chk("req_ready", ifc.req_ready, rdy_exp);
      chk("bus_own", ifc.bus_own, own_left > 0);
      if (own_left > 0) begin
        chk("inputmode", ifc.o_inputmode, REF_RESULT);
        chk("raddr", ifc.o_raddr, cur_addr);
      end
      chk("out_valid", ifc.out_valid, streaming);
      if (streaming && q.size() > 0) begin
        chk("out_data", ifc.out_data, q[0].data);
        chk("out_idx", ifc.out_idx, q[0].idx);
        chk("out_last", ifc.out_last, q[0].last);
      end
      if (ifc.bus_own) own_run++;
      else if (own_run > 0) begin last_own_len = own_run; own_run = 0; end
    end
  // core read data is valid only in the RD_LATENCY-th cycle after issue; garbage otherwise
  initial begin
    int c;
    logic [3:0] pat;
    c = 0; pat = 4'b1001;
    ifc.out_ready = 1; ifc.result_bus = '0;
    forever begin
      @(negedge clk);
      c++;
      ifc.out_ready = bp ? pat[c % 4] : 1'b1;
      for (int k = 0; k < 24; k++)
        ifc.result_bus[k*64 +: 64] = (own_left > 0 && RD_LATENCY + 2 - own_left == RD_LATENCY) ? cur_base + 64'(k) : 64'hDEAD_BEEF_0000_0000 | 64'(k);
    end
  end
  task automatic do_req(input logic [7:0] a, input logic [63:0] b, input int busy);
    int n, owned;
    @(negedge clk);
    mem_base = b; ifc.req_addr = a; ifc.req_valid = 1; ifc.core_busy = busy > 0;
    n = 0;
    while (!ifc.req_ready && n < 50) begin @(negedge clk); n++; end
    chk("req_accepted", ifc.req_ready, 1);
    @(negedge clk);
    ifc.req_valid = 0;
    owned = 0;
    for (int i = 0; i < busy; i++) begin
      owned += int'(ifc.bus_own);
      chk("busy_ready_low", ifc.req_ready, 0);
      @(negedge clk);
    end
    if (busy > 0) chk("busy_no_issue", owned, 0);
    ifc.core_busy = 0;
  endtask
  task automatic wait_done(input int max);
    int n;
    n = 0;
    while (active && n < max) begin @(negedge clk); n++; end
    chk("done_in_time", active, 0);
  endtask
  task automatic chk_elem(input string name, input logic [63:0] base);
    chk({name, "_beats"}, log.size(), NB);
    if (log.size() >= 24)
      for (int k = 0; k < 24; k++) begin
        chk({name, "_data"}, log[k].data, base + 64'(k));
        chk({name, "_idx"}, log[k].idx, k);
      end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    logic [63:0] x;
    ifc.req_valid = 0; ifc.req_addr = 0; ifc.core_busy = 0;
    repeat (3) @(negedge clk);
    chk("rst_out_data", ifc.out_data, 0);
    chk("rst_out_idx", ifc.out_idx, 0);
    chk("rst_req_ready", ifc.req_ready, 0);
    chk("rst_inputmode", ifc.o_inputmode, 0);
    chk("rst_raddr", ifc.o_raddr, 0);
    rst = 0;
    @(negedge clk);
    chk("idle_ready", ifc.req_ready, 1);
    log.delete();
    do_req(RAM_P_B2_0, 64'h1000, 0);
    wait_done(200);
    chk_elem("basic", 64'h1000);
    chk("basic_own_len", last_own_len, 5);
    if (log.size() >= NB) begin
      chk("basic_first", log[0].data, 64'h1000);
      chk("basic_w23", log[23].data, 64'h1017);
      chk("basic_last", log[NB-1].last, 1);
      chk("basic_last_idx", log[NB-1].idx, NB - 1);
`ifdef UNLOAD_CHECKSUM_EN
      x = 0;
      for (int k = 0; k < 24; k++) x = x ^ (64'h1000 + 64'(k));
      chk("cs_data", log[24].data, x);
      chk("cs_w23_not_last", log[23].last, 0);
`endif
    end
    log.delete();
    do_req(8'h41, 64'h2000, 10);
    wait_done(200);
    chk_elem("busy", 64'h2000);
    log.delete();
    bp = 1;
    do_req(8'h42, 64'h3000, 0);
    wait_done(400);
    bp = 0;
    chk_elem("backpressure", 64'h3000);
    log.delete();
    do_req(8'h43, 64'h4000, 0);
    n = 0;
    while (log.size() < 7 && n < 200) begin @(negedge clk); n++; end
    chk("reached_beat7", log.size(), 7);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_valid", ifc.out_valid, 0);
    chk("rst_mid_own", ifc.bus_own, 0);
    rst = 0;
    @(negedge clk);
    log.delete();
    do_req(8'h44, 64'h5000, 0);
    wait_done(200);
    chk_elem("after_rst", 64'h5000);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
